// File: rtl/pito_hart_irq_ctrl.sv
// Per-hart machine-mode interrupt controller for the barrel-threaded pito core.
// Latches MSI/MTI/MEI/MVU sources, masks them, and issues one prioritised trap request per hart.
module pito_hart_irq_ctrl #(
   parameter  int NUM_HARTS = 8,
   parameter  int XPR_LEN   = 32,
   parameter  bit MVU_EDGE  = 1'b1,
   localparam int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_HARTS-1:0]           msip_i,
   input  logic [NUM_HARTS-1:0]           mtip_i,
   input  logic [NUM_HARTS-1:0]           meip_i,
   input  logic [NUM_HARTS-1:0]           mvu_irq_i,
   input  logic [NUM_HARTS*XPR_LEN-1:0]   mie_i,
   input  logic [NUM_HARTS-1:0]           mstatus_mie_i,
   input  logic [NUM_HARTS-1:0]           irq_ack_i,
   input  logic [NUM_HARTS-1:0]           mret_i,
   input  logic                           mip_clr_we_i,
   input  logic [HART_W-1:0]              mip_clr_hart_i,
   input  logic [HART_W-1:0]              mip_rd_hart_i,
   output logic [XPR_LEN-1:0]             mip_rd_o,
   output logic [NUM_HARTS-1:0]           irq_req_o,
   output logic [NUM_HARTS*XPR_LEN-1:0]   irq_cause_o
);

   // state   | meaning
   // ST_IDLE | waiting for an enabled source
   // ST_REQ  | trap request raised, cause frozen until ack
   // ST_TRAP | hart in trap handler, sources ignored until MRET
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_TRAP} state_t;

   state_t               state_q [NUM_HARTS];
   state_t               state_d [NUM_HARTS];
   logic [XPR_LEN-1:0]   cause_q [NUM_HARTS];
   logic [XPR_LEN-1:0]   cause_d [NUM_HARTS];
   logic [XPR_LEN-1:0]   mip_w   [NUM_HARTS];
   logic [3:0]           en      [NUM_HARTS];
   logic [NUM_HARTS-1:0] req_q, req_d;
   logic [NUM_HARTS-1:0] pend_q, pend_d;
   logic [NUM_HARTS-1:0] prev_q, prev_d;
   logic [NUM_HARTS-1:0] mvu_rise, clr_hit;
   logic [XPR_LEN-1:0]   mip_rd_q, mip_rd_d;
   logic                 ready_q, ready_d;
   logic                 unused_mie;

   assign unused_mie = ^mie_i;

   // en bit order: [3] MVU, [2] MEI, [1] MSI, [0] MTI
   function automatic logic [XPR_LEN-1:0] cause_of(input logic [3:0] e);
      logic [4:0] code;
      if (e[2])      code = 5'd11;
      else if (e[1]) code = 5'd3;
      else if (e[0]) code = 5'd7;
      else           code = 5'd16;
      cause_of = {1'b1, {(XPR_LEN-6){1'b0}}, code};
   endfunction

   always_comb begin
      prev_d = mvu_irq_i;
      for (int h = 0; h < NUM_HARTS; h++) begin
         mvu_rise[h] = mvu_irq_i[h] & ~prev_q[h];
         clr_hit[h]  = mip_clr_we_i && (mip_clr_hart_i == HART_W'(h));
         if (MVU_EDGE) pend_d[h] = mvu_rise[h] | (pend_q[h] & ~clr_hit[h]);
         else          pend_d[h] = mvu_irq_i[h];
         mip_w[h]     = '0;
         mip_w[h][16] = pend_q[h];
         mip_w[h][11] = meip_i[h];
         mip_w[h][7]  = mtip_i[h];
         mip_w[h][3]  = msip_i[h];
         // MVU uses the next pending value so a fresh edge meets single-cycle latency
         en[h] = {pend_d[h] & mie_i[h*XPR_LEN+16],
                  meip_i[h] & mie_i[h*XPR_LEN+11],
                  msip_i[h] & mie_i[h*XPR_LEN+3],
                  mtip_i[h] & mie_i[h*XPR_LEN+7]} & {4{mstatus_mie_i[h]}};
      end
   end

   always_comb begin
      ready_d = 1'b1;
      req_d   = req_q;
      for (int h = 0; h < NUM_HARTS; h++) begin
         state_d[h] = state_q[h];
         cause_d[h] = cause_q[h];
         case (state_q[h])
            ST_IDLE: begin
               if (ready_q && (en[h] != 4'd0)) begin
                  state_d[h] = ST_REQ;
                  req_d[h]   = 1'b1;
                  cause_d[h] = cause_of(en[h]);
               end
            end
            ST_REQ: begin
               if (irq_ack_i[h]) begin
                  state_d[h] = ST_TRAP;
                  req_d[h]   = 1'b0;
               end
            end
            ST_TRAP: begin
               if (mret_i[h]) state_d[h] = ST_IDLE;
            end
            default: begin
               state_d[h] = ST_IDLE;
               req_d[h]   = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      mip_rd_d = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (mip_rd_hart_i == HART_W'(h)) mip_rd_d = mip_w[h];
      end
   end

   // ready_q holds the FSMs off for the first cycle after reset release
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q  <= 1'b0;
         req_q    <= '0;
         pend_q   <= '0;
         prev_q   <= '0;
         mip_rd_q <= '0;
         for (int h = 0; h < NUM_HARTS; h++) begin
            state_q[h] <= ST_IDLE;
            cause_q[h] <= '0;
         end
      end else begin
         ready_q  <= ready_d;
         req_q    <= req_d;
         pend_q   <= pend_d;
         prev_q   <= prev_d;
         mip_rd_q <= mip_rd_d;
         for (int h = 0; h < NUM_HARTS; h++) begin
            state_q[h] <= state_d[h];
            cause_q[h] <= cause_d[h];
         end
      end
   end

   always_comb begin
      irq_cause_o = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         irq_cause_o[h*XPR_LEN +: XPR_LEN] = cause_q[h];
      end
   end

   assign irq_req_o = req_q;
   assign mip_rd_o  = mip_rd_q;

endmodule

// File: tb/tb_pito_hart_irq_ctrl.sv
// Directed testbench for pito_hart_irq_ctrl with NUM_HARTS=8, XPR_LEN=32, MVU_EDGE=1.
module tb_pito_hart_irq_ctrl;
   localparam int NH = 8;
   localparam int XL = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [NH-1:0]  msip, mtip, meip, mvu, mstatus_mie, ack, mret;
   logic [NH*XL-1:0] mie;
   logic           clr_we;
   logic [2:0]     clr_hart, rd_hart;
   logic [XL-1:0]  mip_rd;
   logic [NH-1:0]  req;
   logic [NH*XL-1:0] cause;

   int total = 0;
   int passed = 0;

   pito_hart_irq_ctrl #(.NUM_HARTS(NH), .XPR_LEN(XL), .MVU_EDGE(1'b1)) dut (
      .clk(clk), .rst(rst),
      .msip_i(msip), .mtip_i(mtip), .meip_i(meip), .mvu_irq_i(mvu),
      .mie_i(mie), .mstatus_mie_i(mstatus_mie),
      .irq_ack_i(ack), .mret_i(mret),
      .mip_clr_we_i(clr_we), .mip_clr_hart_i(clr_hart), .mip_rd_hart_i(rd_hart),
      .mip_rd_o(mip_rd), .irq_req_o(req), .irq_cause_o(cause)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   // advance one edge; inputs change and outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      msip = '0; mtip = '0; meip = '0; mvu = '0; mstatus_mie = '0;
      ack = '0; mret = '0; mie = '0; clr_we = 1'b0; clr_hart = '0; rd_hart = '0;
   endtask

   function automatic logic [XL-1:0] cause_of(input int h);
      return cause[h*XL +: XL];
   endfunction

   task automatic test_reset();
      zero_inputs();
      rst = 1'b1;
      tick(); tick();
      total++; if (req !== 8'h00) $display("FAIL reset_req: got %h want 00", req); else passed++;
      total++; if (cause !== '0) $display("FAIL reset_cause: got %h want 0", cause); else passed++;
      total++; if (mip_rd !== 32'h0) $display("FAIL reset_mip_rd: got %h want 0", mip_rd); else passed++;
      rst = 1'b0;
      tick(); tick();
   endtask

   task automatic test_priority();
      mie[2*XL +: XL] = 32'h808; mstatus_mie[2] = 1'b1; meip[2] = 1'b1; msip[2] = 1'b1;
      tick();
      total++; if (req !== 8'h04) $display("FAIL prio_req: got %h want 04", req); else passed++;
      total++; if (cause_of(2) !== 32'h8000000B) $display("FAIL prio_cause: got %h want 8000000B", cause_of(2)); else passed++;
      meip[2] = 1'b0; msip[2] = 1'b0; mret[2] = 1'b1;
      tick();
      mret[2] = 1'b0;
      total++; if (req !== 8'h04) $display("FAIL req_hold_on_drop_mret: got %h want 04", req); else passed++;
      total++; if (cause_of(2) !== 32'h8000000B) $display("FAIL cause_frozen: got %h want 8000000B", cause_of(2)); else passed++;
      ack[2] = 1'b1; tick(); ack[2] = 1'b0;
      mret[2] = 1'b1; tick(); mret[2] = 1'b0;
      ack[2] = 1'b1; tick(); ack[2] = 1'b0;
      total++; if (req !== 8'h00) $display("FAIL ack_in_idle: got %h want 00", req); else passed++;
      zero_inputs();
   endtask

   task automatic test_mvu();
      mie[5*XL +: XL] = 32'h10000; mstatus_mie[5] = 1'b1; rd_hart = 3'd5;
      mvu[5] = 1'b1;
      tick();
      mvu[5] = 1'b0;
      total++; if (req !== 8'h20) $display("FAIL mvu_req: got %h want 20", req); else passed++;
      total++; if (cause_of(5) !== 32'h80000010) $display("FAIL mvu_cause: got %h want 80000010", cause_of(5)); else passed++;
      tick();
      total++; if (mip_rd !== 32'h10000) $display("FAIL mvu_mip_rd: got %h want 00010000", mip_rd); else passed++;
      ack[5] = 1'b1; tick(); ack[5] = 1'b0;
      mvu[5] = 1'b1; clr_we = 1'b1; clr_hart = 3'd5;
      tick();
      clr_we = 1'b0; mvu[5] = 1'b0;
      tick();
      total++; if (mip_rd !== 32'h10000) $display("FAIL mvu_set_wins: got %h want 00010000", mip_rd); else passed++;
      clr_we = 1'b1; clr_hart = 3'd5;
      tick();
      clr_we = 1'b0;
      tick();
      total++; if (mip_rd !== 32'h0) $display("FAIL mvu_clear: got %h want 0", mip_rd); else passed++;
      mret[5] = 1'b1; tick(); mret[5] = 1'b0;
      tick();
      total++; if (req !== 8'h00) $display("FAIL mvu_no_rereq: got %h want 00", req); else passed++;
      zero_inputs();
   endtask

   task automatic test_trap_hold();
      mie[0 +: XL] = 32'h800; mstatus_mie[0] = 1'b1; meip[0] = 1'b1;
      tick();
      total++; if (req !== 8'h01) $display("FAIL trap_req: got %h want 01", req); else passed++;
      ack[0] = 1'b1; tick(); ack[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if (req !== 8'h00) $display("FAIL trap_hold_%0d: got %h want 00", i, req); else passed++;
         tick();
      end
      mret[0] = 1'b1; tick(); mret[0] = 1'b0;
      total++; if (req !== 8'h00) $display("FAIL mret_cycle: got %h want 00", req); else passed++;
      tick();
      total++; if (req !== 8'h01) $display("FAIL rereq_after_mret: got %h want 01", req); else passed++;
      meip[0] = 1'b0;
      ack[0] = 1'b1; tick(); ack[0] = 1'b0;
      mret[0] = 1'b1; tick(); mret[0] = 1'b0;
      zero_inputs();
   endtask

   task automatic test_gie();
      mie[1*XL +: XL] = 32'h10888; mstatus_mie[1] = 1'b0;
      msip[1] = 1'b1; mtip[1] = 1'b1; meip[1] = 1'b1; mvu[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (req[1] !== 1'b0) $display("FAIL gie_off_%0d: got %b want 0", i, req[1]); else passed++;
      end
      mstatus_mie[1] = 1'b1;
      tick();
      total++; if (req[1] !== 1'b1) $display("FAIL gie_on_req: got %b want 1", req[1]); else passed++;
      total++; if (cause_of(1) !== 32'h8000000B) $display("FAIL gie_cause: got %h want 8000000B", cause_of(1)); else passed++;
      msip[1] = 1'b0; mtip[1] = 1'b0; meip[1] = 1'b0; mvu[1] = 1'b0;
      clr_we = 1'b1; clr_hart = 3'd1; ack[1] = 1'b1;
      tick();
      clr_we = 1'b0; ack[1] = 1'b0;
      mret[1] = 1'b1; tick(); mret[1] = 1'b0;
      tick();
      total++; if (req !== 8'h00) $display("FAIL gie_cleanup: got %h want 00", req); else passed++;
      zero_inputs();
   endtask

   task automatic test_all_harts();
      for (int h = 0; h < NH; h++) mie[h*XL +: XL] = 32'h80;
      mstatus_mie = 8'hFF; mtip = 8'hFF;
      tick();
      mtip = 8'h00;
      total++; if (req !== 8'hFF) $display("FAIL all_req: got %h want FF", req); else passed++;
      for (int h = 0; h < NH; h++) begin
         total++; if (cause_of(h) !== 32'h80000007) $display("FAIL all_cause_%0d: got %h want 80000007", h, cause_of(h)); else passed++;
      end
      ack = 8'h01; tick();
      total++; if (req !== 8'hFE) $display("FAIL stagger_0: got %h want FE", req); else passed++;
      ack = 8'h08; tick();
      total++; if (req !== 8'hF6) $display("FAIL stagger_3: got %h want F6", req); else passed++;
      ack = 8'h00; mret = 8'h01; tick(); mret = 8'h00;
      total++; if (req !== 8'hF6) $display("FAIL stagger_mret0: got %h want F6", req); else passed++;
      ack = 8'hF6; tick(); ack = 8'h00;
      total++; if (req !== 8'h00) $display("FAIL stagger_rest: got %h want 00", req); else passed++;
      mret = 8'hFF; tick(); mret = 8'h00;
      zero_inputs();
   endtask

   task automatic test_reset_mid();
      mie[3*XL +: XL] = 32'h800; mstatus_mie[3] = 1'b1; meip[3] = 1'b1; rd_hart = 3'd3;
      tick();
      total++; if (req !== 8'h08) $display("FAIL rm_req: got %h want 08", req); else passed++;
      ack[3] = 1'b1; tick(); ack[3] = 1'b0;
      total++; if (mip_rd !== 32'h800) $display("FAIL rm_mip_rd: got %h want 00000800", mip_rd); else passed++;
      rst = 1'b1;
      tick();
      total++; if (req !== 8'h00) $display("FAIL rm_req_rst: got %h want 00", req); else passed++;
      total++; if (cause !== '0) $display("FAIL rm_cause_rst: got %h want 0", cause); else passed++;
      total++; if (mip_rd !== 32'h0) $display("FAIL rm_mip_rd_rst: got %h want 0", mip_rd); else passed++;
      rst = 1'b0;
      tick();
      total++; if (req !== 8'h00) $display("FAIL rm_release_1: got %h want 00", req); else passed++;
      tick();
      total++; if (req !== 8'h08) $display("FAIL rm_release_2: got %h want 08", req); else passed++;
      total++; if (cause_of(3) !== 32'h8000000B) $display("FAIL rm_cause: got %h want 8000000B", cause_of(3)); else passed++;
      zero_inputs();
   endtask

   initial begin
      test_reset();
      test_priority();
      test_mvu();
      test_trap_hold();
      test_gie();
      test_all_harts();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
